nes_joypad_port: RTL and testbench

//  Parametrised NES controller-port engine: samples up to four pads, serialises them to the NES core's
//  two joypad ports ($4016/$4017). Adds over the current inline logic: Four Score 4-pad multiplexing,
//  a free-running joysplitter scan with settle counter, an OSD start/select override and a defined

---
 rtl/nes_joy_pkg.sv | 25 ++
 rtl/nes_pad_shifter.sv | 42 ++++
 rtl/nes_joypad_port.sv | 139 +++++++++++++
 tb/tb_nes_joypad_port.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/nes_joy_pkg.sv
// Shared constants for the NES controller-port engine: button bit positions,
// Four Score signatures and the 24-bit load-word assembly helper.
package nes_joy_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [7:0] FS_SIG_P1 = 8'h10;
    localparam logic [7:0] FS_SIG_P2 = 8'h20;

    typedef logic [7:0] pad_t;

    // Signature byte is read MSB-first as the console expects, so 8'h10 lands on
    // word bit 19 and 8'h20 on word bit 20 (sig[0] is always 0 and is dropped).
    function automatic logic [23:0] fs_word(input pad_t sig, input pad_t pad_b, input pad_t pad_a);
        return {1'b0, sig[7:1], pad_b, pad_a};
    endfunction

endpackage

// File: rtl/nes_pad_shifter.sv
// One NES joypad port: parallel load while strobe is high, shift right on each
// falling edge of the port read pulse, refilling from the top with FILL_BIT.
module nes_pad_shifter
    import nes_joy_pkg::*;
#(
    parameter int W        = 8,
    parameter bit FILL_BIT = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_strobe,
    input  logic         i_joy_clk,
    input  logic [W-1:0] i_load,
    output logic         o_data
);

    logic         r_last_clk;
    logic [W-1:0] r_shreg;
    logic         w_fall;

    assign w_fall = r_last_clk & ~i_joy_clk;

    // Reload has priority over a read edge in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_clk <= 1'b0;
            r_shreg    <= '0;
        end else begin
            r_last_clk <= i_joy_clk;
            if (i_strobe) begin
                r_shreg <= i_load;
            end else if (w_fall) begin
                r_shreg <= {FILL_BIT, r_shreg[W-1:1]};
            end else begin
                r_shreg <= r_shreg;
            end
        end
    end

    assign o_data = r_shreg[0];

endmodule

// File: rtl/nes_joypad_port.sv
// NES controller-port engine: pad pin synchroniser, optional joysplitter scan,
// OSD Start/Select merge and (optionally Four Score) serialisation to two ports.
module nes_joypad_port
    import nes_joy_pkg::*;
#(
    parameter int NUM_PADS     = 2,
    parameter int FOURSCORE    = 0,
    parameter int SPLIT_MODE   = 0,
    parameter int SPLIT_PERIOD = 1024,
    parameter bit FILL_BIT     = 1'b1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_PADS*8-1:0] pad_raw,
    input  logic                  osd_select,
    input  logic                  osd_start,
    input  logic                  joy_strobe,
    input  logic [1:0]            joy_clk,
    output logic [1:0]            joy_data,
    output logic                  split_sel,
    output logic [NUM_PADS*8-1:0] pads_q
);

    localparam int PW = NUM_PADS * 8;
    localparam int W  = (FOURSCORE != 0) ? 24 : 8;

    logic [PW-1:0] r_sync [SYNC_STAGES];
    logic [PW-1:0] w_pressed;
    logic [PW-1:0] w_captured;
    logic [PW-1:0] w_merged;
    logic [PW-1:0] r_pads_q;
    logic [31:0]   w_all;
    logic [W-1:0]  w_load0;
    logic [W-1:0]  w_load1;
    logic          w_split_sel;

    // Pin synchroniser; released pins are high, so the chain resets to all ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '1;
            end
        end else begin
            r_sync[0] <= pad_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_pressed = ~r_sync[SYNC_STAGES-1];

    if (SPLIT_MODE != 0) begin : g_split
        localparam int CW = $clog2(SPLIT_PERIOD);
        logic [CW-1:0] r_ctr;
        logic          r_sel;
        pad_t          r_cap0;
        pad_t          r_cap1;

        // Scan counter; the shared pins are sampled one cycle before split_sel flips.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_ctr  <= '0;
                r_sel  <= 1'b1;
                r_cap0 <= 8'h00;
                r_cap1 <= 8'h00;
            end else begin
                if (r_ctr == CW'(SPLIT_PERIOD - 1)) begin
                    r_ctr <= '0;
                    r_sel <= ~r_sel;
                end else begin
                    r_ctr <= r_ctr + {{(CW-1){1'b0}}, 1'b1};
                end
                if (r_ctr == CW'(SPLIT_PERIOD - 2)) begin
                    if (r_sel) begin
                        r_cap0 <= w_pressed[7:0];
                    end else begin
                        r_cap1 <= w_pressed[7:0];
                    end
                end
            end
        end

        assign w_captured  = PW'({r_cap1, r_cap0});
        assign w_split_sel = r_sel;
    end else begin : g_direct
        assign w_captured  = w_pressed;
        assign w_split_sel = 1'b1;
    end

    // Host overrides act on the captured state so they bypass the synchroniser delay.
    always_comb begin
        w_merged                = w_captured;
        w_merged[BTN_START]     = w_captured[BTN_START]  | osd_start;
        w_merged[BTN_SELECT]    = w_captured[BTN_SELECT] | osd_select;
    end

    // Debug copy of the merged pressed state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pads_q <= '0;
        end else begin
            r_pads_q <= w_merged;
        end
    end

    assign w_all = 32'(w_merged);

    if (FOURSCORE != 0) begin : g_fs
        assign w_load0 = fs_word(FS_SIG_P1, w_all[23:16], w_all[7:0]);
        assign w_load1 = fs_word(FS_SIG_P2, w_all[31:24], w_all[15:8]);
    end else begin : g_std
        assign w_load0 = w_all[7:0];
        assign w_load1 = w_all[15:8];
    end

    nes_pad_shifter #(.W(W), .FILL_BIT(FILL_BIT)) u_port0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_strobe  (joy_strobe),
        .i_joy_clk (joy_clk[0]),
        .i_load    (w_load0),
        .o_data    (joy_data[0])
    );

    nes_pad_shifter #(.W(W), .FILL_BIT(FILL_BIT)) u_port1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_strobe  (joy_strobe),
        .i_joy_clk (joy_clk[1]),
        .i_load    (w_load1),
        .o_data    (joy_data[1])
    );

    assign split_sel = w_split_sel;
    assign pads_q    = r_pads_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Directed scoreboard bench for nes_joypad_port: default, Four Score and
// joysplitter instances share one clock and reset.
module tb_nes_joypad_port;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic [15:0] d_pad = 16'hFFFF;
    logic        d_osel = 1'b0, d_ostart = 1'b0, d_strobe = 1'b0;
    logic [1:0]  d_jclk = 2'b00, d_data;
    logic        d_ssel;
    logic [15:0] d_pq;
    // Four Score instance
    logic [31:0] f_pad = 32'hFFFF_FFFF;
    logic        f_strobe = 1'b0;
    logic [1:0]  f_jclk = 2'b00, f_data;
    logic        f_ssel;
    logic [31:0] f_pq;
    // joysplitter instance
    logic [15:0] s_pad;
    logic        s_ostart = 1'b0;
    logic [1:0]  s_data;
    logic        s_ssel;
    logic [15:0] s_pq;

    // Joysplitter hardware model: pad 0 on the pins while split_sel=1, pad 1 otherwise.
    assign s_pad = {8'h00, (s_ssel ? 8'hAA : 8'hF0)};

    nes_joypad_port u_def (
        .clk(clk), .reset_n(reset_n), .pad_raw(d_pad), .osd_select(d_osel), .osd_start(d_ostart),
        .joy_strobe(d_strobe), .joy_clk(d_jclk), .joy_data(d_data), .split_sel(d_ssel), .pads_q(d_pq)
    );

    nes_joypad_port #(.NUM_PADS(4), .FOURSCORE(1)) u_fs (
        .clk(clk), .reset_n(reset_n), .pad_raw(f_pad), .osd_select(1'b0), .osd_start(1'b0),
        .joy_strobe(f_strobe), .joy_clk(f_jclk), .joy_data(f_data), .split_sel(f_ssel), .pads_q(f_pq)
    );

    nes_joypad_port #(.SPLIT_MODE(1), .SPLIT_PERIOD(16)) u_spl (
        .clk(clk), .reset_n(reset_n), .pad_raw(s_pad), .osd_select(1'b0), .osd_start(s_ostart),
        .joy_strobe(1'b0), .joy_clk(2'b00), .joy_data(s_data), .split_sel(s_ssel), .pads_q(s_pq)
    );

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed %h, no expected entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic obs_bit(input int inst, input int port);
        return (inst == 0) ? d_data[port] : f_data[port];
    endfunction

    // One read pulse; returns at the negedge after the falling edge has been registered.
    task automatic pulse(input int inst, input int port);
        if (inst == 0) d_jclk[port] = 1'b1; else f_jclk[port] = 1'b1;
        tick(1);
        if (inst == 0) d_jclk[port] = 1'b0; else f_jclk[port] = 1'b0;
        tick(1);
    endtask

    task automatic strobe(input int inst);
        if (inst == 0) d_strobe = 1'b1; else f_strobe = 1'b1;
        tick(4);
        if (inst == 0) d_strobe = 1'b0; else f_strobe = 1'b0;
        tick(1);
    endtask

    // Reads nbits of word then extra fill bits, pulsing after each sample.
    task automatic read_word(input int inst, input int port, input string tag,
                             input logic [23:0] word, input int nbits, input int extra);
        for (int i = 0; i < nbits + extra; i++) begin
            push($sformatf("%s_b%0d", tag, i), (i < nbits) ? 16'(word[i]) : 16'h0001);
            check(16'(obs_bit(inst, port)));
            pulse(inst, port);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        // reset state
        push("rst_joy_data", 16'h0000); check(16'(d_data));
        push("rst_split_sel_def", 16'h0001); check(16'(d_ssel));
        push("rst_split_sel_spl", 16'h0001); check(16'(s_ssel));
        push("rst_pads_q", 16'h0000); check(d_pq);
        reset_n = 1'b1;
        tick(2);

        // pad0 A, pad1 B; port1 serial read with fill, port2 untouched
        d_pad = 16'hFD_FE;
        strobe(0);
        read_word(0, 0, "t1_p1", 24'h000001, 8, 3);
        read_word(0, 1, "t1_p2", 24'h000002, 8, 2);
        push("t1_pads_q", 16'h0201); check(d_pq);

        // strobe high with a falling read edge: reload wins, data tracks live A
        d_strobe = 1'b1;
        tick(4);
        d_jclk[0] = 1'b1; tick(1);
        d_jclk[0] = 1'b0; tick(1);
        push("t3_fall_in_strobe", 16'h0001); check(16'(d_data[0]));
        d_pad = 16'hFFFF; tick(4);
        push("t3_live_release", 16'h0000); check(16'(d_data[0]));
        d_pad = 16'hFFFE; tick(4);
        push("t3_live_press", 16'h0001); check(16'(d_data[0]));
        d_strobe = 1'b0; tick(1);
        push("t3_after_strobe", 16'h0001); check(16'(d_data[0]));
        pulse(0, 0);
        push("t3_first_shift", 16'h0000); check(16'(d_data[0]));

        // Four Score: pad2 Start only
        f_pad = 32'hFFF7_FFFF;
        strobe(1);
        read_word(1, 0, "t2_fs_p1", 24'h080800, 24, 3);
        read_word(1, 1, "t2_fs_p2", 24'h100000, 24, 2);
        push("t2_fs_split_sel", 16'h0001); check(16'(f_ssel));

        // joysplitter: both pads captured by now, then osd_start acts in one cycle
        tick(40);
        push("t4_split_pads", 16'h0F55); check(s_pq);
        s_ostart = 1'b1; tick(1);
        push("t4_split_osd", 16'h0F5D); check(s_pq);
        s_ostart = 1'b0;

        // OSD start with all pins released
        d_pad = 16'hFFFF; d_ostart = 1'b1;
        strobe(0);
        read_word(0, 0, "t5_osd", 24'h000008, 8, 1);
        d_ostart = 1'b0;
        strobe(0);
        read_word(0, 0, "t5_clear", 24'h000000, 8, 1);

        // reset mid-read
        d_pad = 16'hFFFE;
        strobe(0);
        read_word(0, 0, "t6_pre", 24'h000001, 3, 0);
        reset_n = 1'b0; #1;
        push("t6_rst_data", 16'h0000); check(16'(d_data));
        push("t6_rst_split_sel", 16'h0001); check(16'(s_ssel));
        tick(2);
        reset_n = 1'b1;
        tick(4);
        push("t6_idle_data", 16'h0000); check(16'(d_data[0]));
        strobe(0);
        read_word(0, 0, "t6_fresh", 24'h000001, 8, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
